// File: rtl/inst_data_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_data_arbiter_pkg
// Purpose  : Shared definitions for the instruction/data RAM arbiter:
//            response owner encoding, starvation limit default, in-flight
//            tag record layout and the starvation counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package inst_data_arbiter_pkg;

  // Default number of consecutive MEM grants tolerated while IF waits.
  localparam int STARVE_LIMIT_DEF = 4;

  // Which requester owns the read currently in flight.
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // One-deep in-flight read tag; err flags a misaligned fetch.
  typedef struct packed {
    logic   valid;
    owner_e owner;
    logic   err;
  } tag_t;

  localparam tag_t TAG_NONE = '{valid: 1'b0, owner: OWN_IF, err: 1'b0};

  // Counter width able to hold the limit value, never narrower than 3 bits.
  function automatic int starve_cnt_width(input int limit);
    int w;
    w = 1;
    while ((1 << w) <= limit) w++;
    if (w < 3) w = 3;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/inst_data_arbiter_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module   : arb_starve_cnt
// Purpose  : Counts MEM grants issued while a fetch request is pending and
//            flags starvation once the count reaches STARVE_LIMIT.
// Ports    : clk, reset     - clock, asynchronous active-high reset
//            if_req         - fetch request pending
//            if_gnt         - fetch granted this cycle
//            mem_gnt        - data access granted this cycle
//            starve         - IF must win arbitration this cycle
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_cnt
  import inst_data_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  parameter int CNT_W        = starve_cnt_width(STARVE_LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic if_gnt,
  input  logic mem_gnt,
  output logic starve
);

  localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!if_req || if_gnt) begin
      r_cnt <= '0;
    end else if (mem_gnt && (r_cnt != LIMIT_V)) begin
      // Saturating guard; at the limit IF wins, so this rarely matters.
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign starve = if_req && (r_cnt == LIMIT_V);

endmodule
`default_nettype wire

// File: rtl/inst_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : inst_data_arbiter
// Purpose  : Arbitrates a single-ported synchronous RAM between instruction
//            fetch (IF) and data access (MEM). MEM has priority; a starvation
//            counter forces an IF grant after STARVE_LIMIT consecutive MEM
//            grants. Reads return exactly one cycle after the grant.
// Ports    : clk, reset                    - clock, async active-high reset
//            if_req/if_addr/if_flush       - fetch request, address, cancel
//            if_gnt/if_rvalid/if_rdata/if_err - fetch grant and response
//            mem_req/mem_wen/mem_addr/mem_wdata - data request
//            mem_gnt/mem_rvalid/mem_rdata  - data grant and load response
//            ram_en/ram_wen/ram_addr/ram_wdata/ram_rdata - shared RAM port
// Revision : 1.0 - initial release
// ============================================================================
module inst_data_arbiter
  import inst_data_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  // Instruction fetch port
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  output logic        if_err,
  // Data access port
  input  logic        mem_req,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  // Shared RAM port
  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  logic w_starve;
  logic w_if_win;
  logic w_if_mis;
  logic w_if_resp;
  tag_t w_tag_nxt;
  tag_t r_tag;

  arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_starve_cnt (
    .clk     (clk),
    .reset   (reset),
    .if_req  (if_req),
    .if_gnt  (if_gnt),
    .mem_gnt (mem_gnt),
    .starve  (w_starve)
  );

  // IF wins when MEM is idle or when IF has been starved long enough.
  assign w_if_win = if_req && (!mem_req || w_starve);
  assign w_if_mis = |if_addr[1:0];

  // Grants are forced low while reset is asserted.
  assign if_gnt  = !reset && w_if_win;
  assign mem_gnt = !reset && mem_req && !w_if_win;

  // RAM port steering from the granted requester.
  always_comb begin
    ram_en    = 1'b0;
    ram_wen   = 4'h0;
    ram_addr  = 32'h0;
    ram_wdata = 32'h0;
    if (mem_gnt) begin
      ram_en    = 1'b1;
      ram_wen   = mem_wen;
      ram_addr  = mem_addr;
      ram_wdata = mem_wdata;
    end else if (if_gnt) begin
      // A misaligned fetch never touches the RAM; it only returns an error.
      ram_en    = !w_if_mis;
      ram_addr  = if_addr;
    end
  end

  // Next in-flight tag: one entry per read grant, none for writes.
  always_comb begin
    w_tag_nxt = TAG_NONE;
    if (mem_gnt) begin
      w_tag_nxt.valid = (mem_wen == 4'h0);
      w_tag_nxt.owner = OWN_MEM;
    end else if (if_gnt) begin
      // A flush in the grant cycle kills the fetch before it is tracked.
      w_tag_nxt.valid = !if_flush;
      w_tag_nxt.owner = OWN_IF;
      w_tag_nxt.err   = w_if_mis;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag <= TAG_NONE;
    end else begin
      r_tag <= w_tag_nxt;
    end
  end

  // Response decode; a flush in the response cycle also drops the fetch.
  assign w_if_resp  = r_tag.valid && (r_tag.owner == OWN_IF);
  assign if_rvalid  = w_if_resp && !if_flush;
  assign if_err     = if_rvalid && r_tag.err;
  assign if_rdata   = (if_rvalid && !r_tag.err) ? ram_rdata : 32'h0;

  assign mem_rvalid = r_tag.valid && (r_tag.owner == OWN_MEM);
  assign mem_rdata  = mem_rvalid ? ram_rdata : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_inst_data_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_data_arbiter
// Purpose  : Self-checking bench for inst_data_arbiter. Directed vectors
//            check grants and RAM steering in the request cycle and push the
//            expected read responses into per-port queues; a monitor pops
//            and compares whenever the DUT presents if_rvalid/mem_rvalid.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_data_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_flush = 1'b0;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic [3:0]  mem_wen = 4'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  logic [32:0] if_q[$];   // {err, data}
  logic [31:0] mem_q[$];
  bit          prev_if_pushed = 1'b0;

  inst_data_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM contents: the boot vector word, otherwise a pattern from the address.
  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a == 32'hBFC0_0000) ? 32'h2408_0001 : (a ^ 32'hA5A5_0000);
  endfunction

  // External synchronous RAM: read data one cycle after a read enable.
  always @(posedge clk) begin
    if (ram_en && ram_wen == 4'h0) ram_rdata <= rd_val(ram_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    if (if_rvalid === 1'b1) begin
      if (if_q.size() == 0) begin
        chk("if_rvalid_unexpected", 32'(if_rvalid), 32'h0);
      end else begin
        logic [32:0] e;
        e = if_q.pop_front();
        chk("if_rdata", if_rdata, e[31:0]);
        chk("if_err", 32'(if_err), 32'(e[32]));
      end
    end else begin
      chk("if_rdata_idle", if_rdata, 32'h0);
    end
    if (mem_rvalid === 1'b1) begin
      if (mem_q.size() == 0) begin
        chk("mem_rvalid_unexpected", 32'(mem_rvalid), 32'h0);
      end else begin
        logic [31:0] e;
        e = mem_q.pop_front();
        chk("mem_rdata", mem_rdata, e);
      end
    end else begin
      chk("mem_rdata_idle", mem_rdata, 32'h0);
    end
  end

  // One request cycle: drive, check grants/RAM steering, queue responses.
  task automatic apply(input logic ir, input logic [31:0] ia, input logic fl,
                       input logic mr, input logic [3:0] mw, input logic [31:0] ma,
                       input logic [31:0] md, input logic e_if, input logic e_mem);
    logic        x_en;
    logic [3:0]  x_wen;
    logic [31:0] x_addr, x_wd;
    if_req = ir; if_addr = ia; if_flush = fl;
    mem_req = mr; mem_wen = mw; mem_addr = ma; mem_wdata = md;
    if (fl && prev_if_pushed) void'(if_q.pop_back());
    prev_if_pushed = 1'b0;
    x_en = 1'b0; x_wen = 4'h0; x_addr = 32'h0; x_wd = 32'h0;
    if (e_mem) begin
      x_en = 1'b1; x_wen = mw; x_addr = ma; x_wd = md;
    end else if (e_if) begin
      x_en = (ia[1:0] == 2'b00); x_addr = ia;
    end
    @(negedge clk);
    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("mem_gnt", 32'(mem_gnt), 32'(e_mem));
    chk("ram_en", 32'(ram_en), 32'(x_en));
    chk("ram_wen", 32'(ram_wen), 32'(x_wen));
    chk("ram_addr", ram_addr, x_addr);
    chk("ram_wdata", ram_wdata, x_wd);
    if (e_if && !fl) begin
      if_q.push_back((ia[1:0] == 2'b00) ? {1'b0, rd_val(ia)} : {1'b1, 32'h0});
      prev_if_pushed = 1'b1;
    end
    if (e_mem && mw == 4'h0) mem_q.push_back(rd_val(ma));
    @(posedge clk); #1;
  endtask

  task automatic idle();
    apply(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_gnt"}, 32'(if_gnt), 32'h0);
    chk({tag, "_mem_gnt"}, 32'(mem_gnt), 32'h0);
    chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'h0);
    chk({tag, "_if_err"}, 32'(if_err), 32'h0);
    chk({tag, "_mem_rvalid"}, 32'(mem_rvalid), 32'h0);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'h0);
    chk({tag, "_ram_wen"}, 32'(ram_wen), 32'h0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    // Reset with both requests raised: everything must stay quiet.
    if_req = 1'b1; mem_req = 1'b1; if_addr = 32'h40; mem_addr = 32'h200;
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Boot fetch, granted in the first cycle after reset release.
    apply(1'b1, 32'hBFC0_0000, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Both requesting: MEM x4, IF on starvation, then MEM again.
    for (int i = 0; i < 6; i++) begin
      apply(1'b1, 32'h40, 1'b0, 1'b1, 4'h0, 32'h200 + 32'(i * 4), 32'h0,
            (i == 4), (i != 4));
    end
    idle();

    // Store: write enables and data steered, no load response.
    apply(1'b0, 32'h0, 1'b0, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b1);
    idle();

    // Misaligned fetch: RAM untouched, error response with zero data.
    apply(1'b1, 32'hBFC0_0002, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Flush in response cycle while a MEM read is granted.
    apply(1'b1, 32'h80, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    apply(1'b0, 32'h0, 1'b1, 1'b1, 4'h0, 32'h300, 32'h0, 1'b0, 1'b1);
    idle();
    // Flush in grant cycle: grant still issued, response dropped.
    apply(1'b1, 32'h84, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle();

    // Reset one cycle after a MEM read grant: the load must vanish.
    apply(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h400, 32'h0, 1'b0, 1'b1);
    reset = 1'b1; if_req = 1'b1; mem_req = 1'b1; mem_addr = 32'h404;
    mem_q.delete();
    prev_if_pushed = 1'b0;
    @(negedge clk);
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    apply(1'b0, 32'h0, 1'b0, 1'b1, 4'h0, 32'h408, 32'h0, 1'b0, 1'b1);
    idle();
    idle();

    chk("if_q_drained", 32'(if_q.size()), 32'h0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_data_arbiter.md
INST_DATA_ARBITER -- requirements
Module: inst_data_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive MEM grants allowed while IF waits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 if_req  input  1  fetch read request.
REQ-005 if_addr  input  32  fetch word address.
REQ-006 if_flush  input  1  cancel outstanding fetch result (exception or jump redirect).
REQ-007 if_gnt  output  1  fetch request accepted this cycle.
REQ-008 if_rvalid  output  1  fetch data valid.
REQ-009 if_rdata  output  32  fetch instruction word.
REQ-010 if_err  output  1  with if_rvalid: misaligned fetch address.
REQ-011 mem_req  input  1  data access request.
REQ-012 mem_wen  input  4  byte write enables; 0 means read.
REQ-013 mem_addr  input  32  data address.
REQ-014 mem_wdata  input  32  store data.
REQ-015 mem_gnt  output  1  data request accepted this cycle.
REQ-016 mem_rvalid  output  1  load data valid.
REQ-017 mem_rdata  output  32  load data.
REQ-018 ram_en  output  1  shared synchronous RAM enable.
REQ-019 ram_wen  output  4  RAM byte write enables.
REQ-020 ram_addr  output  32  RAM address.
REQ-021 ram_wdata  output  32  RAM write data.
REQ-022 ram_rdata  input  32  RAM read data, valid one cycle after ram_en with ram_wen=0.

Function
REQ-023 Grants combinational in request cycle; at most one of if_gnt/mem_gnt high per cycle.
REQ-024 Default priority MEM over IF.
REQ-025 Starvation counter (3 bits min) increments on each mem_gnt while if_req high, clears on if_gnt or when if_req low; when counter equals STARVE_LIMIT and if_req high, IF wins that cycle.
REQ-026 Granted requester's address/wen/wdata drive ram_* combinationally; ram_en=1 except for a misaligned fetch (if_addr[1:0]!=0), where ram_en=0.
REQ-027 No grant: ram_en=0, ram_wen=0, ram_addr/ram_wdata hold 0.
REQ-028 Registered in-flight tag {valid, owner, err} captured on each grant of a read; writes create no tag and produce no rvalid.
REQ-029 Read latency exactly one cycle: rvalid of tag owner high in the cycle after grant; rdata = ram_rdata (0 for non-owner).
REQ-030 Misaligned fetch: if_rvalid=1, if_err=1, if_rdata=0 next cycle.
REQ-031 Back-to-back grants every cycle supported; no bubble required.
REQ-032 if_flush in grant cycle or response cycle suppresses if_rvalid for that fetch; flush does not block a new if_gnt in the same cycle.
REQ-033 if_flush never affects MEM tags.

Reset
REQ-034 While reset high: all grants, rvalid, err, ram_en, ram_wen 0; tag invalid; starvation counter 0.
REQ-035 Reset asserted mid-transaction discards the in-flight tag; no rvalid emitted after release.
REQ-036 First grant possible in the first clk edge cycle after reset deasserts.

Structure
REQ-037 Shared package holds owner encoding (OWN_IF, OWN_MEM), STARVE_LIMIT default, and tag record layout.
REQ-038 Single module; optional sub-module arb_starve_cnt for the starvation counter.

Verification
REQ-039 if_req only, if_addr=0xBFC00000, ram_rdata=0x24080001 next cycle -> if_gnt same cycle, if_rvalid=1, if_rdata=0x24080001 one cycle later.
REQ-040 Both req held, mem_wen=0, STARVE_LIMIT=4 -> mem_gnt cycles 0-3, if_gnt cycle 4, mem_gnt cycle 5.
REQ-041 mem_req store wen=0xF addr=0x100 data=0xDEADBEEF -> ram_wen=0xF, ram_wdata=0xDEADBEEF, no mem_rvalid.
REQ-042 if_addr=0xBFC00002 -> ram_en=0, next cycle if_rvalid=1, if_err=1, if_rdata=0.
REQ-043 Fetch granted, if_flush high next cycle -> if_rvalid stays 0; concurrent mem read completes normally.
REQ-044 Reset pulsed one cycle after a MEM read grant -> mem_rvalid never asserts; all outputs 0 during reset.
